// File: rtl/ret_addr_stack_pkg.sv
// Shared CPU constants for the return-address stack: default geometry and
// the overflow-policy encoding used by the pipeline slices.
package ret_addr_stack_pkg;

   localparam int RAS_WIDTH = 16;
   localparam int RAS_DEPTH = 8;

   // Push-when-full policy: wrap overwrites the oldest entry, drop discards the push.
   localparam bit OVF_MODE_DROP = 1'b0;
   localparam bit OVF_MODE_WRAP = 1'b1;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: pushed by retiring Calls and popped by retiring
// Rets; provides the predicted return PC on top_addr.
module ret_addr_stack
   import ret_addr_stack_pkg::*;
#(
   parameter int WIDTH    = RAS_WIDTH,
   parameter int DEPTH    = RAS_DEPTH,
   parameter bit OVF_WRAP = OVF_MODE_WRAP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_addr,
   input  logic                       pop,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           top_addr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       ovf,
   output logic                       udf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    tp_q, tp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             wr_en;
   logic [PW-1:0]    wr_idx;
   logic [PW-1:0]    top_idx;

   // DEPTH is a power of two, so pointer arithmetic wraps for free.
   assign top_idx  = tp_q - 1'b1;
   assign top_addr = (cnt_q != '0) ? mem_q[top_idx] : '0;
   assign count    = cnt_q;
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CNT_FULL);
   assign ovf      = ovf_q;
   assign udf      = udf_q;

   always_comb begin
      tp_d   = tp_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      wr_en  = 1'b0;
      wr_idx = tp_q;
      if (!stall) begin
         // Clear first so an error event in the same cycle wins.
         if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
         end
         if (push && pop) begin
            if (cnt_q != '0) begin
               wr_en  = 1'b1;
               wr_idx = top_idx;
            end else begin
               wr_en = 1'b1;
               tp_d  = tp_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
               udf_d = 1'b1;
            end
         end else if (push) begin
            if (cnt_q != CNT_FULL) begin
               wr_en = 1'b1;
               tp_d  = tp_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
               if (OVF_WRAP) begin
                  wr_en = 1'b1;
                  tp_d  = tp_q + 1'b1;
               end
            end
         end else if (pop) begin
            if (cnt_q != '0) begin
               tp_d  = tp_q - 1'b1;
               cnt_d = cnt_q - 1'b1;
            end else begin
               udf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_idx] <= push_addr;
      end
   end

endmodule
